sync_fifo_flex: RTL

Parametrised synchronous FIFO, successor to the team's basic RAM-backed FIFO, for stream buffering between eduSOC peripherals and the CPU bus. It adds:
- a selectable output mode: standard one-cycle-latency read, or first-word-fall-through (FWFT) with a registered head word;
- registered programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a synchronous flush.

Storage is a dual-port distributed RAM with combinational read.

---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo_flex.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the flexible synchronous FIFO.
package sync_fifo_pkg;

  function automatic int unsigned depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

  // The FWFT head register adds one word of storage on top of the RAM.
  function automatic int unsigned capacity(input int unsigned awidth, input int unsigned fwft);
    return depth(awidth) + ((fwft != 0) ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned addr_bits(input int unsigned awidth);
    return awidth;
  endfunction

  function automatic int unsigned dcount_bits(input int unsigned awidth);
    return awidth + 32'd1;
  endfunction

  function automatic bit levels_ok(input int unsigned awidth, input int unsigned fwft,
                                   input int unsigned af, input int unsigned ae);
    int unsigned cap;
    cap = capacity(awidth, fwft);
    return (af >= 32'd1) && (af <= cap) && (ae + 32'd1 <= cap);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DWIDTH storage: synchronous write, combinational read (read-before-write on collision).
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata_c
);

  localparam int unsigned DEPTH = depth(AWIDTH);

  (* ram_style = "distributed" *) logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with standard or first-word-fall-through output, registered
// level flags, sticky error flags and synchronous flush.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned AWIDTH   = 4,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = (32'd1 << AWIDTH) - 32'd2,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              re,
  output logic [DWIDTH-1:0] dout,
  output logic [AWIDTH:0]   dcount,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CAP = capacity(AWIDTH, FWFT);
  localparam int unsigned AW  = addr_bits(AWIDTH);
  localparam int unsigned CW  = dcount_bits(AWIDTH);

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] dcount_t;

  localparam dcount_t CAP_C = CW'(CAP);
  localparam dcount_t AF_C  = CW'(AF_LEVEL);
  localparam dcount_t AE_C  = CW'(AE_LEVEL);

  if (!levels_ok(AWIDTH, FWFT, AF_LEVEL, AE_LEVEL)) begin : g_level_check
    $error("sync_fifo_flex: AF_LEVEL or AE_LEVEL outside the legal range");
  end

  addr_t             wr_addr;
  addr_t             rd_addr;
  dcount_t           dcount_next;
  logic              wr_ok;
  logic              rd_ok;
  logic              ram_we;
  logic              rd_inc;
  logic              load;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] ram_rdata;

  // Flush takes priority over any request in the same cycle.
  assign wr_ok = we & ~full  & ~flush;
  assign rd_ok = re & ~empty & ~flush;

  sync_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (wr_addr),
    .wdata   (din),
    .raddr   (rd_addr),
    .rdata_c (ram_rdata)
  );

  if (FWFT == 0) begin : g_std
    assign ram_we    = wr_ok;
    assign rd_inc    = rd_ok;
    assign load      = rd_ok;
    assign load_data = ram_rdata;
  end else begin : g_fwft
    logic head_valid;
    logic head_load;
    logic ram_has;

    // Words held in the RAM are the occupancy minus the head word.
    assign ram_has = (dcount != CW'(head_valid));

    // Head refills from the RAM first; a write into an empty RAM bypasses straight into the head.
    always_comb begin
      head_load = ~flush & (~head_valid | rd_ok);
      ram_we    = wr_ok;
      rd_inc    = 1'b0;
      load      = 1'b0;
      load_data = ram_rdata;
      if (head_load) begin
        if (ram_has) begin
          rd_inc = 1'b1;
          load   = 1'b1;
        end else if (wr_ok) begin
          ram_we    = 1'b0;
          load      = 1'b1;
          load_data = din;
        end
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)        head_valid <= 1'b0;
      else if (flush)     head_valid <= 1'b0;
      else if (head_load) head_valid <= ram_has | wr_ok;
    end
  end

  always_comb begin
    dcount_next = dcount;
    if (flush)                dcount_next = '0;
    else if (wr_ok && !rd_ok) dcount_next = dcount + CW'(1);
    else if (rd_ok && !wr_ok) dcount_next = dcount - CW'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (flush) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      wr_addr <= wr_addr + AW'(ram_we);
      rd_addr <= rd_addr + AW'(rd_inc);
    end
  end

  // Level flags are registered from the next occupancy so they track the edge that changes it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dcount       <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      dcount       <= dcount_next;
      empty        <= (dcount_next == '0);
      full         <= (dcount_next == CAP_C);
      almost_full  <= (dcount_next >= AF_C);
      almost_empty <= (dcount_next <= AE_C);
      overflow     <= ~flush & (overflow  | (we & full));
      underflow    <= ~flush & (underflow | (re & empty));
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)   dout <= '0;
    else if (load) dout <= load_data;
  end

endmodule
